// File: rtl/apb_requester.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// apb_requester
//
// Queues read/write commands in a small FIFO and plays them out as APB
// transfers (IDLE -> SETUP -> ACCESS). Every transfer ends with a single-cycle
// rsp_valid pulse carrying read data and an error flag. A transfer whose
// completer never raises PREADY is aborted after TIMEOUT ACCESS cycles and
// reported as an error.
//
// Ports
//   PCLK, RESET        clock (rising edge) and asynchronous active-high reset
//   cmd_valid/ready    command handshake; cmd_ready reflects FIFO space
//   cmd_write          1 = write, 0 = read
//   cmd_addr/wdata     command address and write data
//   PSLEx, PENABLE     APB select / enable (registered)
//   PWRITE, PADDAR     APB direction / address (registered, held when idle)
//   PWDATA             APB write data (registered, held when idle)
//   PREADY, PSLVERR,   completer handshake, error and read data
//   PRDATA
//   rsp_valid          one-cycle completion pulse
//   rsp_rdata, rsp_err completion data (0 for writes and aborts) and error
//   busy               FSM not idle or commands still queued
// -----------------------------------------------------------------------------
module apb_requester #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8,
  parameter int CMD_DEPTH  = 4,   // power of two, at least 2
  parameter int TIMEOUT    = 15   // ACCESS cycles allowed without PREADY
) (
  input  logic                  PCLK,
  input  logic                  RESET,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  PSLEx,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [ADDR_WIDTH-1:0] PADDAR,
  output logic [DATA_WIDTH-1:0] PWDATA,
  input  logic                  PREADY,
  input  logic                  PSLVERR,
  input  logic [DATA_WIDTH-1:0] PRDATA,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  busy
);

  localparam int PTR_W  = (CMD_DEPTH > 1) ? $clog2(CMD_DEPTH) : 1;
  localparam int CNT_W  = $clog2(CMD_DEPTH + 1);
  localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int ENT_W  = 1 + ADDR_WIDTH + DATA_WIDTH;

  localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(CMD_DEPTH);
  // The wait counter holds the number of ACCESS cycles already spent without
  // PREADY; seeing this value on a further non-ready cycle means the current
  // cycle is the TIMEOUT-th one, so the transfer is aborted at its end.
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // Command FIFO
  // ---------------------------------------------------------------------------
  logic [ENT_W-1:0]  mem [CMD_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic [ENT_W-1:0]  head;
  logic              push;
  logic              pop;
  logic              fifo_empty;

  // cmd_ready comes purely from the registered count, so a pop in the same
  // cycle never opens room for a push into a full FIFO.
  assign cmd_ready  = (count < DEPTH_C);
  assign push       = cmd_valid && cmd_ready;
  assign fifo_empty = (count == '0);
  assign head       = mem[rd_ptr];

  always_ff @(posedge PCLK or posedge RESET) begin
    if (RESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage carries data only; emptiness is tracked by count, so it needs no reset.
  always_ff @(posedge PCLK) begin
    if (push) mem[wr_ptr] <= {cmd_write, cmd_addr, cmd_wdata};
  end

  // ---------------------------------------------------------------------------
  // Transfer FSM: next-state and next-output logic
  // ---------------------------------------------------------------------------
  state_t                state;
  state_t                state_nx;
  logic [WAIT_W-1:0]     wait_cnt;
  logic [WAIT_W-1:0]     wait_nx;
  logic                  psel_nx;
  logic                  penable_nx;
  logic                  pwrite_nx;
  logic [ADDR_WIDTH-1:0] paddr_nx;
  logic [DATA_WIDTH-1:0] pwdata_nx;
  logic                  rsp_valid_nx;
  logic                  rsp_err_nx;
  logic [DATA_WIDTH-1:0] rsp_rdata_nx;
  logic                  done;

  always_comb begin
    state_nx     = state;
    wait_nx      = wait_cnt;
    psel_nx      = PSLEx;
    penable_nx   = PENABLE;
    pwrite_nx    = PWRITE;
    paddr_nx     = PADDAR;
    pwdata_nx    = PWDATA;
    rsp_valid_nx = 1'b0;
    rsp_err_nx   = rsp_err;
    rsp_rdata_nx = rsp_rdata;
    pop          = 1'b0;
    done         = 1'b0;

    case (state)
      IDLE: begin
        psel_nx    = 1'b0;
        penable_nx = 1'b0;
        if (!fifo_empty) begin
          pop                              = 1'b1;
          {pwrite_nx, paddr_nx, pwdata_nx} = head;
          psel_nx                          = 1'b1;
          wait_nx                          = '0;
          state_nx                         = SETUP;
        end
      end

      SETUP: begin
        psel_nx    = 1'b1;
        penable_nx = 1'b1;
        state_nx   = ACCESS;
      end

      ACCESS: begin
        if (PREADY) begin
          done         = 1'b1;
          rsp_valid_nx = 1'b1;
          rsp_err_nx   = PSLVERR;
          rsp_rdata_nx = PWRITE ? '0 : PRDATA;
        end else if (wait_cnt == WAIT_LAST) begin
          done         = 1'b1;
          rsp_valid_nx = 1'b1;
          rsp_err_nx   = 1'b1;
          rsp_rdata_nx = '0;
        end else begin
          wait_nx = wait_cnt + WAIT_W'(1);
        end

        // A finishing transfer chains straight into the next SETUP when a
        // command is waiting, giving one transfer every two cycles.
        if (done) begin
          if (!fifo_empty) begin
            pop                              = 1'b1;
            {pwrite_nx, paddr_nx, pwdata_nx} = head;
            psel_nx                          = 1'b1;
            penable_nx                       = 1'b0;
            wait_nx                          = '0;
            state_nx                         = SETUP;
          end else begin
            psel_nx    = 1'b0;
            penable_nx = 1'b0;
            state_nx   = IDLE;
          end
        end
      end

      default: begin
        psel_nx    = 1'b0;
        penable_nx = 1'b0;
        state_nx   = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Transfer FSM: state and registered APB / response outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge PCLK or posedge RESET) begin
    if (RESET) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      PSLEx     <= 1'b0;
      PENABLE   <= 1'b0;
      PWRITE    <= 1'b0;
      PADDAR    <= '0;
      PWDATA    <= '0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      state     <= state_nx;
      wait_cnt  <= wait_nx;
      PSLEx     <= psel_nx;
      PENABLE   <= penable_nx;
      PWRITE    <= pwrite_nx;
      PADDAR    <= paddr_nx;
      PWDATA    <= pwdata_nx;
      rsp_valid <= rsp_valid_nx;
      rsp_err   <= rsp_err_nx;
      rsp_rdata <= rsp_rdata_nx;
    end
  end

  assign busy = (state != IDLE) || !fifo_empty;

endmodule

// File: tb/tb_apb_requester.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_apb_requester
//
// Directed bench for apb_requester. A memory-backed completer answers APB
// transfers with a programmable number of wait states, optional PSLVERR and
// optional PREADY noise outside ACCESS. Single-command cases are table driven;
// reset, latency, back-to-back and abort-then-continue are hand sequences.
// -----------------------------------------------------------------------------
module tb_apb_requester;

  localparam int AW = 4;
  localparam int DW = 8;

  logic          PCLK = 1'b0;
  logic          RESET;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          PSLEx;
  logic          PENABLE;
  logic          PWRITE;
  logic [AW-1:0] PADDAR;
  logic [DW-1:0] PWDATA;
  logic          PREADY;
  logic          PSLVERR;
  logic [DW-1:0] PRDATA;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          busy;

  always #5 PCLK = ~PCLK;

  apb_requester #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .CMD_DEPTH  (4),
    .TIMEOUT    (15)
  ) dut (
    .PCLK      (PCLK),
    .RESET     (RESET),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_write (cmd_write),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .PSLEx     (PSLEx),
    .PENABLE   (PENABLE),
    .PWRITE    (PWRITE),
    .PADDAR    (PADDAR),
    .PWDATA    (PWDATA),
    .PREADY    (PREADY),
    .PSLVERR   (PSLVERR),
    .PRDATA    (PRDATA),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .busy      (busy)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Completer model and response monitor (runs on the falling edge)
  // ---------------------------------------------------------------------------
  logic [DW-1:0]   tmem [16];
  int              dly_q[$];
  int              cfg_delay      = 0;
  bit              cfg_err        = 1'b0;
  bit              cfg_idle_ready = 1'b0;
  logic [DW-1:0]   cfg_err_data   = 8'h3C;
  logic [DW:0]     rsp_q[$];
  int              acc_q[$];
  logic [AW+DW:0]  setup_q[$];
  logic [AW+DW:0]  last_setup;
  int              idle_cnt = 0;
  int              acc_cyc  = 0;
  int              acc_last = 0;
  int              cur_dly  = 0;

  initial begin
    PREADY  = 1'b0;
    PSLVERR = 1'b0;
    PRDATA  = '0;
    last_setup = '0;
    for (int i = 0; i < 16; i++) tmem[i] = DW'(8'h10 + i);
    forever begin
      @(negedge PCLK);
      if (RESET) begin
        acc_cyc = 0;
        PREADY  = 1'b0;
        PSLVERR = 1'b0;
      end else begin
        if (rsp_valid) begin
          rsp_q.push_back({rsp_err, rsp_rdata});
          acc_q.push_back(acc_last);
        end
        if (!PSLEx) idle_cnt++;
        if (PSLEx && !PENABLE) begin
          last_setup = {PWRITE, PADDAR, PWDATA};
          setup_q.push_back(last_setup);
        end
        if (PSLEx && PENABLE) begin
          check("access_hold", 32'({PWRITE, PADDAR, PWDATA}), 32'(last_setup));
          if (acc_cyc == 0) begin
            if (dly_q.size() > 0) cur_dly = dly_q.pop_front();
            else                  cur_dly = cfg_delay;
          end
          acc_cyc++;
          acc_last = acc_cyc;
          if (acc_cyc > cur_dly) begin
            PREADY  = 1'b1;
            PSLVERR = cfg_err;
            if (cfg_err) PRDATA = cfg_err_data;
            else         PRDATA = tmem[PADDAR];
            if (PWRITE && !cfg_err) tmem[PADDAR] = PWDATA;
          end else begin
            PREADY  = 1'b0;
            PSLVERR = 1'b0;
            PRDATA  = 8'hEE;
          end
        end else begin
          acc_cyc = 0;
          PREADY  = cfg_idle_ready;
          PSLVERR = cfg_idle_ready;
          PRDATA  = 8'hEE;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  task automatic push(input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    int guard;
    guard     = 0;
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr  = a;
    cmd_wdata = d;
    while (!cmd_ready && guard < 60) begin
      tick();
      guard++;
    end
    check("push_ready", 32'(cmd_ready), 32'd1);
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int n);
    int guard;
    guard = 0;
    while (rsp_q.size() < n && guard < 80) begin
      tick();
      guard++;
    end
    check("rsp_arrived", 32'(rsp_q.size() >= n), 32'd1);
  endtask

  task automatic clear_model();
    rsp_q.delete();
    acc_q.delete();
    setup_q.delete();
    dly_q.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_psel"},      32'(PSLEx),     32'd0);
    check({tag, "_penable"},   32'(PENABLE),   32'd0);
    check({tag, "_pwrite"},    32'(PWRITE),    32'd0);
    check({tag, "_paddr"},     32'(PADDAR),    32'd0);
    check({tag, "_pwdata"},    32'(PWDATA),    32'd0);
    check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    check({tag, "_rsp_err"},   32'(rsp_err),   32'd0);
    check({tag, "_rsp_rdata"}, 32'(rsp_rdata), 32'd0);
    check({tag, "_busy"},      32'(busy),      32'd0);
    check({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
  endtask

  typedef struct {
    bit            wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    int            dly;
    bit            err;
    bit            idle_rdy;
    bit            exp_err;
    logic [DW-1:0] exp_rdata;
    int            exp_acc;
  } vec_t;

  vec_t vecs[12];

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  initial begin
    logic [DW:0] r;
    int          idle0;

    // wr, addr, wdata, wait states, PSLVERR, PREADY outside ACCESS,
    // expected err, expected rdata, expected ACCESS cycles
    vecs[0]  = '{1'b1, 4'h3, 8'hA5,   0, 1'b0, 1'b0, 1'b0, 8'h00,  1};
    vecs[1]  = '{1'b0, 4'h3, 8'h00,   0, 1'b0, 1'b0, 1'b0, 8'hA5,  1};
    vecs[2]  = '{1'b1, 4'h7, 8'h5A,   2, 1'b0, 1'b0, 1'b0, 8'h00,  3};
    vecs[3]  = '{1'b0, 4'h7, 8'h00,   1, 1'b0, 1'b0, 1'b0, 8'h5A,  2};
    vecs[4]  = '{1'b0, 4'h3, 8'h00,   0, 1'b1, 1'b0, 1'b1, 8'h3C,  1};
    vecs[5]  = '{1'b1, 4'h1, 8'hFF,   0, 1'b1, 1'b0, 1'b1, 8'h00,  1};
    vecs[6]  = '{1'b0, 4'hF, 8'h00,   0, 1'b0, 1'b1, 1'b0, 8'h1F,  1};
    vecs[7]  = '{1'b0, 4'h4, 8'h00,  14, 1'b0, 1'b0, 1'b0, 8'h14, 15};
    vecs[8]  = '{1'b0, 4'h2, 8'h00, 100, 1'b0, 1'b0, 1'b1, 8'h00, 15};
    vecs[9]  = '{1'b1, 4'h0, 8'h77, 100, 1'b0, 1'b0, 1'b1, 8'h00, 15};
    vecs[10] = '{1'b0, 4'h0, 8'h00,   3, 1'b0, 1'b1, 1'b0, 8'h10,  4};
    vecs[11] = '{1'b1, 4'h9, 8'hC3,  13, 1'b0, 1'b0, 1'b0, 8'h00, 14};

    RESET     = 1'b1;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    tick();
    tick();
    check_reset_outputs("reset");
    RESET = 1'b0;

    // Push into an empty idle FIFO: SETUP two edges later, then completion.
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_addr  = 4'h6;
    cmd_wdata = 8'h66;
    tick();
    cmd_valid = 1'b0;
    check("lat_idle_psel", 32'(PSLEx), 32'd0);
    check("lat_busy",      32'(busy),  32'd1);
    tick();
    check("lat_setup", 32'({PSLEx, PENABLE, PWRITE, PADDAR, PWDATA}), 32'({1'b1, 1'b0, 1'b1, 4'h6, 8'h66}));
    tick();
    check("lat_access", 32'({PSLEx, PENABLE}), 32'd3);
    tick();
    check("lat_rsp", 32'({rsp_valid, rsp_err, rsp_rdata, PSLEx}), 32'({1'b1, 1'b0, 8'h00, 1'b0}));
    tick();
    check("lat_rsp_pulse", 32'(rsp_valid), 32'd0);
    check("idle_hold", 32'({PWRITE, PADDAR, PWDATA}), 32'({1'b1, 4'h6, 8'h66}));
    clear_model();

    // Abort on timeout, then the queued command still runs.
    dly_q.push_back(100);
    dly_q.push_back(0);
    push(1'b0, 4'h2, 8'h00);
    push(1'b0, 4'h5, 8'h00);
    wait_rsp(2);
    if (rsp_q.size() >= 2) begin
      check("to_rsp0", 32'(rsp_q[0]), 32'({1'b1, 8'h00}));
      check("to_acc0", 32'(acc_q[0]), 32'd15);
      check("to_rsp1", 32'(rsp_q[1]), 32'({1'b0, 8'h15}));
      check("to_acc1", 32'(acc_q[1]), 32'd1);
    end
    clear_model();

    // Back-to-back: first transfer stalls long enough to fill the FIFO.
    dly_q = '{6, 0, 0, 0, 0, 0};
    idle0 = 0;
    for (int k = 0; k < 6; k++) begin
      push(1'b1, AW'(8 + k), DW'(8'h80 + k));
      if (k == 0) idle0 = idle_cnt;
      if (k == 4) check("b2b_full_ready", 32'(cmd_ready), 32'd0);
    end
    wait_rsp(6);
    check("b2b_idle_cycles", 32'(idle_cnt - idle0), 32'd2);
    if (rsp_q.size() >= 6 && setup_q.size() >= 6) begin
      for (int k = 0; k < 6; k++) begin
        check($sformatf("b2b_rsp%0d", k),   32'(rsp_q[k]),   32'({1'b0, 8'h00}));
        check($sformatf("b2b_acc%0d", k),   32'(acc_q[k]),   (k == 0) ? 32'd7 : 32'd1);
        check($sformatf("b2b_setup%0d", k), 32'(setup_q[k]), 32'({1'b1, AW'(8 + k), DW'(8'h80 + k)}));
      end
    end
    clear_model();

    // Reset during ACCESS with two commands queued.
    dly_q.push_back(100);
    push(1'b1, 4'h4, 8'h44);
    push(1'b0, 4'h5, 8'h00);
    push(1'b0, 4'h6, 8'h00);
    check("pre_reset_access", 32'({PSLEx, PENABLE}), 32'd3);
    #2;
    RESET = 1'b1;
    #1;
    check_reset_outputs("midrst");
    tick();
    tick();
    RESET = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    check("midrst_no_rsp",  32'(rsp_q.size()), 32'd0);
    check("midrst_dropped", 32'({busy, PSLEx}), 32'd0);
    clear_model();

    // Single-command table.
    for (int i = 0; i < 12; i++) begin
      cfg_delay      = vecs[i].dly;
      cfg_err        = vecs[i].err;
      cfg_idle_ready = vecs[i].idle_rdy;
      clear_model();
      push(vecs[i].wr, vecs[i].addr, vecs[i].wdata);
      wait_rsp(1);
      if (rsp_q.size() >= 1 && setup_q.size() >= 1) begin
        r = rsp_q[0];
        check($sformatf("v%0d_err", i),   32'(r[DW]),          32'(vecs[i].exp_err));
        check($sformatf("v%0d_rdata", i), 32'(r[DW-1:0]),      32'(vecs[i].exp_rdata));
        check($sformatf("v%0d_acc", i),   32'(acc_q[0]),       32'(vecs[i].exp_acc));
        check($sformatf("v%0d_setup", i), 32'(setup_q[0]),
              32'({vecs[i].wr, vecs[i].addr, vecs[i].wdata}));
      end
      check($sformatf("v%0d_idle", i), 32'({busy, PSLEx, PENABLE}), 32'd0);
    end
    cfg_idle_ready = 1'b0;
    cfg_err        = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/apb_requester.md
APB_REQUESTER -- requirements
Module: apb_requester

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 4, APB address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 8, APB data width.
REQ-003 SHALL have parameter CMD_DEPTH, default 4, command FIFO entries (power of two).
REQ-004 SHALL have parameter TIMEOUT, default 15, max ACCESS cycles without PREADY before abort.
REQ-005 SHALL have port PCLK, input, 1, the single clock; all logic on its rising edge.
REQ-006 SHALL have port RESET, input, 1; reset is asynchronous and active-high.
REQ-007 SHALL have port cmd_valid, input, 1, command offered.
REQ-008 SHALL have port cmd_ready, output, 1, command FIFO can accept.
REQ-009 SHALL have port cmd_write, input, 1, 1=write, 0=read.
REQ-010 SHALL have port cmd_addr, input, ADDR_WIDTH, target address.
REQ-011 SHALL have port cmd_wdata, input, DATA_WIDTH, write data.
REQ-012 SHALL have port PSLEx, output, 1, APB select.
REQ-013 SHALL have port PENABLE, output, 1, APB enable.
REQ-014 SHALL have port PWRITE, output, 1, APB direction.
REQ-015 SHALL have port PADDAR, output, ADDR_WIDTH, APB address.
REQ-016 SHALL have port PWDATA, output, DATA_WIDTH, APB write data.
REQ-017 SHALL have ports PREADY, input, 1; PSLVERR, input, 1; PRDATA, input, DATA_WIDTH (from completer).
REQ-018 SHALL have port rsp_valid, output, 1, one-cycle completion pulse.
REQ-019 SHALL have ports rsp_rdata, output, DATA_WIDTH, and rsp_err, output, 1, completion data and error.
REQ-020 SHALL have port busy, output, 1, high when FSM not IDLE or FIFO non-empty.

Function
REQ-021 SHALL push {cmd_write, cmd_addr, cmd_wdata} into the FIFO on any edge with cmd_valid && cmd_ready.
REQ-022 SHALL drive cmd_ready = (count < CMD_DEPTH) from registered count; a push at full is ignored even if a pop occurs that cycle.
REQ-023 SHALL implement FSM states IDLE, SETUP, ACCESS; all APB outputs registered.
REQ-024 IDLE: PSLEx=0, PENABLE=0; if FIFO non-empty, pop head into PWRITE/PADDAR/PWDATA and go to SETUP next edge.
REQ-025 SETUP: PSLEx=1, PENABLE=0, exactly one cycle, then ACCESS.
REQ-026 ACCESS: PSLEx=1, PENABLE=1; PWRITE/PADDAR/PWDATA stable from SETUP until ACCESS exits.
REQ-027 ACCESS with PREADY=1: complete; next cycle rsp_valid=1, rsp_err=PSLVERR, rsp_rdata=PRDATA for reads, 0 for writes.
REQ-028 On completion, if FIFO non-empty, pop next command and go directly to SETUP (no IDLE cycle); else IDLE.
REQ-029 ACCESS with PREADY=0 SHALL increment a wait counter (reset to 0 on entering SETUP).
REQ-030 When wait counter reaches TIMEOUT with PREADY=0, abort: rsp_valid=1, rsp_err=1, rsp_rdata=0, then per REQ-028.
REQ-031 PREADY SHALL be ignored outside ACCESS; PSLVERR/PRDATA sampled only on the completing edge.
REQ-032 Minimum transfer: 2 cycles (SETUP+ACCESS); back-to-back throughput one transfer per 2 cycles.
REQ-033 A push into an empty FIFO while IDLE SHALL reach SETUP two edges later (push edge, pop edge).
REQ-034 When idle, PADDAR/PWDATA/PWRITE SHALL hold their last values.

Reset
REQ-035 RESET=1 SHALL immediately force IDLE, empty FIFO, wait counter 0, PSLEx=0, PENABLE=0, PWRITE=0, PADDAR=0, PWDATA=0, rsp_valid=0, rsp_err=0, rsp_rdata=0, busy=0, cmd_ready=1.
REQ-036 RESET asserted mid-transfer SHALL drop the in-flight and queued commands with no rsp_valid pulse.

Verification
REQ-037 Write addr 3 data 0xA5, PREADY=1 in ACCESS -> SETUP then ACCESS with PADDAR=3, PWDATA=0xA5, PWRITE=1; rsp_valid=1, rsp_err=0.
REQ-038 Read addr 3 after REQ-037 against a memory completer -> rsp_rdata=0xA5, rsp_err=0.
REQ-039 Push 5 commands back-to-back with PREADY=1 -> cmd_ready=0 after 4th while queued; all 5 complete, no IDLE between transfers.
REQ-040 PREADY held 0 -> abort after 15 ACCESS cycles with rsp_err=1, rsp_rdata=0; next queued command proceeds.
REQ-041 PSLVERR=1 with PREADY=1 on read -> rsp_err=1, rsp_rdata=PRDATA.
REQ-042 RESET during ACCESS with 2 queued -> outputs zero immediately, no rsp_valid, cmd_ready=1.
